// File: rtl/sub16_pkg.sv
// Shared constants and types for the pipelined subtractor.
//   SUB_WIDTH   default operand/result width
//   SUB_SLICE   default bits resolved per pipeline stage
//   SUB_NSTG    default number of pipeline stages (SUB_WIDTH / SUB_SLICE)
//   sub_slice_t one default-width slice of an operand or result
package sub16_pkg;

    localparam int unsigned SUB_WIDTH = 16;
    localparam int unsigned SUB_SLICE = 4;
    localparam int unsigned SUB_NSTG  = SUB_WIDTH / SUB_SLICE;

    typedef logic [SUB_SLICE-1:0] sub_slice_t;

endpackage

// File: rtl/sub_slice_stage.sv
// One registered SLICE-bit add-with-carry stage of the pipelined subtractor.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high; clears s and cout
//   en     in   stage advance; registers load only when set
//   x      in   SLICE-bit minuend slice
//   y_inv  in   SLICE-bit inverted subtrahend slice
//   cin    in   carry into this slice
//   s      out  registered sum slice
//   cout   out  registered carry out of this slice
module sub_slice_stage
    import sub16_pkg::*;
#(
    parameter int unsigned SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y_inv,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE-1:0] gen;
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carry;
    logic [SLICE-1:0] sum;

    // Generate/propagate carry chain; the loop flattens into a lookahead network.
    always_comb begin
        gen      = x & y_inv;
        prop     = x ^ y_inv;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(SLICE); i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum = prop ^ carry[SLICE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else if (en) begin
            s    <= sum;
            cout <= carry[SLICE];
        end
    end

endmodule

// File: rtl/sub_16b_pipe.sv
// Pipelined WIDTH-bit subtractor: diff = a - b, computed as a + ~b + 1, one SLICE-bit slice
// per stage with the carry rippling stage to stage through registers. valid/ready streaming,
// one operation per cycle; the whole pipe advances together (adv) or holds.
// Optional feature macro: SUB16_FLAGS_EN adds the zero and neg result flags.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   operand pair valid
//   in_ready   out  pipe can accept this cycle (= adv)
//   a, b       in   minuend / subtrahend
//   out_valid  out  result valid
//   out_ready  in   consumer takes result this cycle
//   diff       out  a - b modulo 2^WIDTH
//   borrow     out  unsigned a < b
//   ovf        out  signed overflow
//   zero       out  diff == 0            (SUB16_FLAGS_EN only)
//   neg        out  diff[WIDTH-1]        (SUB16_FLAGS_EN only)
module sub_16b_pipe
    import sub16_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH,
    parameter int unsigned SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
`ifdef SUB16_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int unsigned NSTG = WIDTH / SLICE;
    localparam int unsigned MSB  = WIDTH - 1;

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("sub_16b_pipe: WIDTH must be a multiple of SLICE");
    end

    logic             adv;
    logic [WIDTH-1:0] b_inv;
    logic [NSTG-1:0]  valid_q;

    // Per-stage operand copies travel with the op; stage k+1 consumes slice k+1 of stage k's copy.
    logic [WIDTH-1:0] a_q  [NSTG];
    logic [WIDTH-1:0] bn_q [NSTG];
    // lo_q[k]: diff slices already resolved below stage k's own slice.
    logic [WIDTH-1:0] lo_q [NSTG];
    // lo_ins[k]: lo_q[k] with stage k's freshly registered sum slice merged in.
    logic [WIDTH-1:0] lo_ins [NSTG];

    logic [SLICE-1:0] slice_sum [NSTG];
    logic [NSTG-1:0]  slice_cout;

    assign b_inv     = ~b;
    assign out_valid = valid_q[NSTG-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [SLICE-1:0] x;
        logic [SLICE-1:0] y_inv;
        logic             cin;

        if (k == 0) begin : g_first
            assign x     = a[SLICE-1:0];
            assign y_inv = b_inv[SLICE-1:0];
            assign cin   = 1'b1;
        end else begin : g_rest
            assign x     = a_q[k-1][k*SLICE +: SLICE];
            assign y_inv = bn_q[k-1][k*SLICE +: SLICE];
            assign cin   = slice_cout[k-1];
        end

        sub_slice_stage #(
            .SLICE (SLICE)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .x     (x),
            .y_inv (y_inv),
            .cin   (cin),
            .s     (slice_sum[k]),
            .cout  (slice_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(NSTG); k++) begin
            lo_ins[k] = lo_q[k];
            lo_ins[k][k*SLICE +: SLICE] = slice_sum[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < int'(NSTG); k++) begin
                a_q[k]  <= '0;
                bn_q[k] <= '0;
                lo_q[k] <= '0;
            end
        end else if (adv) begin
            // Bubbles shift through exactly like data; their payload is ignored downstream.
            valid_q[0] <= in_valid;
            a_q[0]     <= a;
            bn_q[0]    <= b_inv;
            lo_q[0]    <= '0;
            for (int k = 1; k < int'(NSTG); k++) begin
                valid_q[k] <= valid_q[k-1];
                a_q[k]     <= a_q[k-1];
                bn_q[k]    <= bn_q[k-1];
                lo_q[k]    <= lo_ins[k-1];
            end
        end
    end

    assign diff = lo_ins[NSTG-1];

    // Gated by out_valid so that the cleared carry register reads as no-borrow while idle.
    assign borrow = out_valid & ~slice_cout[NSTG-1];

    // bn_q holds ~b, so the subtrahend sign is its inverse.
    assign ovf = (a_q[NSTG-1][MSB] != ~bn_q[NSTG-1][MSB]) && (diff[MSB] != a_q[NSTG-1][MSB]);

`ifdef SUB16_FLAGS_EN
    assign zero = out_valid & (diff == '0);
    assign neg  = diff[MSB];
`endif

endmodule

// File: tb/tb_sub_16b_pipe.sv
module tb_sub_16b_pipe;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        res_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
`ifdef SUB16_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int   checks;
    int   errors;
    int   cyc;
    int   res_count;
    int   res_cyc [int];
    res_t exp_q [$];
    res_t cur_exp;
    res_t mon_e;
    vec_t tbl [13];

    sub_16b_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
`ifdef SUB16_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
        res_t r;
        r.diff   = x - y;
        r.borrow = (x < y);
        r.ovf    = (x[15] != y[15]) && (r.diff[15] != x[15]);
        return r;
    endfunction

    // Scoreboard: mid-cycle, record accepted ops and compare retiring results in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got diff %h with no op outstanding", diff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result{diff,borrow,ovf}", {14'd0, diff, borrow, ovf}, {14'd0, mon_e});
`ifdef SUB16_FLAGS_EN
                    check("flag_zero", 32'(zero), 32'(mon_e.diff == 16'h0000));
                    check("flag_neg", 32'(neg), 32'(mon_e.diff[15]));
`endif
                    res_cyc[res_count] = cyc;
                    res_count++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic send_op(input logic [15:0] ta, input logic [15:0] tb, input res_t te);
        int n = 0;
        a        = ta;
        b        = tb;
        cur_exp  = te;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int n = 0;
        while (res_count < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("result_count", 32'(res_count), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] x;
        logic [15:0] y;

        //            a         b          diff     borrow ovf
        tbl[0]  = '{16'h1234, 16'h0234, '{16'h1000, 1'b0, 1'b0}};
        tbl[1]  = '{16'h0000, 16'h0001, '{16'hFFFF, 1'b1, 1'b0}};
        tbl[2]  = '{16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b1}};
        tbl[3]  = '{16'h7FFF, 16'hFFFF, '{16'h8000, 1'b1, 1'b1}};
        tbl[4]  = '{16'hFFFF, 16'hFFFF, '{16'h0000, 1'b0, 1'b0}};
        tbl[5]  = '{16'h0005, 16'h0003, '{16'h0002, 1'b0, 1'b0}};
        tbl[6]  = '{16'h0003, 16'h0005, '{16'hFFFE, 1'b1, 1'b0}};
        tbl[7]  = '{16'h8000, 16'h8000, '{16'h0000, 1'b0, 1'b0}};
        tbl[8]  = '{16'h8000, 16'h7FFF, '{16'h0001, 1'b0, 1'b1}};
        tbl[9]  = '{16'h5A5A, 16'h5A5A, '{16'h0000, 1'b0, 1'b0}};
        tbl[10] = '{16'hABCD, 16'h1234, '{16'h9999, 1'b0, 1'b0}};
        tbl[11] = '{16'h1234, 16'hABCD, '{16'h6667, 1'b1, 1'b0}};
        tbl[12] = '{16'h0001, 16'h8000, '{16'h8001, 1'b1, 1'b1}};

        checks    = 0;
        errors    = 0;
        res_count = 0;
        cur_exp   = '0;
        a         = 16'hDEAD;
        b         = 16'h0001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rst       = 1'b1;

        // Reset held 3 cycles with in_valid asserted.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_diff", 32'(diff), 32'd0);
        end
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
`ifdef SUB16_FLAGS_EN
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        check("out_valid_after_rst", 32'(out_valid), 32'd0);

        // Single op: result appears on the fourth edge counting the accept edge.
        a        = tbl[0].a;
        b        = tbl[0].b;
        cur_exp  = tbl[0].exp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("latency_not_early", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("single_diff", 32'(diff), 32'h1000);
        check("single_borrow", 32'(borrow), 32'd0);
        check("single_ovf", 32'(ovf), 32'd0);
        wait_results(1);

        // Directed vector table streamed back-to-back.
        base = res_count;
        foreach (tbl[i]) send_op(tbl[i].a, tbl[i].b, tbl[i].exp);
        wait_results(base + 13);

        // 100 random ops back-to-back; results must come one per cycle.
        base = res_count;
        for (int i = 0; i < 100; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            send_op(x, y, model(x, y));
        end
        wait_results(base + 100);
        check("stream_one_per_cycle", 32'(res_cyc[base + 99] - res_cyc[base]), 32'd99);

        // Backpressure: fill the pipe, stall 5 cycles, then retire + accept on one edge.
        base      = res_count;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_op(tbl[i].a, tbl[i].b, tbl[i].exp);
        check("bp_full_out_valid", 32'(out_valid), 32'd1);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_diff", 32'(diff), 32'h1000);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_diff_held", 32'(diff), 32'h1000);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        send_op(tbl[4].a, tbl[4].b, tbl[4].exp);
        wait_results(base + 5);
        check("bp_no_loss", 32'(exp_q.size()), 32'd0);

        // Mid-stream reset with ops in flight.
        for (int i = 0; i < 4; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            send_op(x, y, model(x, y));
        end
        check("mid_pre_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid_async", 32'(out_valid), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end
        base = res_count;
        send_op(tbl[9].a, tbl[9].b, tbl[9].exp);
        wait_results(base + 1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
